rsa_regfile_ctrl: RTL and testbench

//  Parametrised register bank and run controller for the RSA modular-exponentiation core.

---
 rtl/rsa_regfile_ctrl_if.sv | 20 ++
 rtl/rsa_regfile_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_rsa_regfile_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_regfile_ctrl_if.sv
// ---------------------------------------------------------------------------
// rsa_regfile_ctrl_if
//   Register bus between spireg (master) and rsa_regfile_ctrl (slave).
//   reg_addr   register address
//   reg_wdata  write data
//   reg_wvld   one-cycle write strobe
//   reg_rdata  read data, combinational on reg_addr
// ---------------------------------------------------------------------------
interface rsa_regfile_ctrl_if #(
   parameter int ADDR_W = 5,
   parameter int REG_W  = 8
);
   logic [ADDR_W-1:0] reg_addr;
   logic [REG_W-1:0]  reg_wdata;
   logic              reg_wvld;
   logic [REG_W-1:0]  reg_rdata;

   modport master (output reg_addr, output reg_wdata, output reg_wvld, input reg_rdata);
   modport slave  (input reg_addr, input reg_wdata, input reg_wvld, output reg_rdata);
endinterface

// File: rtl/rsa_regfile_ctrl.sv
// ---------------------------------------------------------------------------
// rsa_regfile_ctrl
//   Register bank and run controller for the RSA modular-exponentiation core.
//   Holds the multi-byte operands P, E, M, CONST, captures result C, and runs
//   an IDLE/RUN/DONE controller with a run timeout and sticky, maskable flags.
//
//   Ports
//     clk, rst            clock, synchronous active-high reset
//     bus (slave)         register bus from spireg (addr/wdata/wvld/rdata)
//     ext_start           asynchronous start pin, rising-edge triggered
//     core_en/core_rst_n  core enable and core reset, both active only in RUN
//     op_p/op_e/op_m/op_const  operands, straight from the register bytes
//     core_eoc, core_c    end-of-computation strobe and result from the core
//     irq                 level interrupt, mirrors STATUS.IRQ
//
//   Map: 0 STATUS (RO), 1 CTRL, 2 CLR (W1C), 3 spare, then OP_BYTES-byte
//   little-endian blocks P, E, M, CONST, C (RO).
// ---------------------------------------------------------------------------
module rsa_regfile_ctrl #(
   parameter int REG_W    = 8,
   parameter int ADDR_W   = 5,
   parameter int OP_BYTES = 4,
   parameter int TMO_W    = 16,
   localparam int OP_W    = OP_BYTES * REG_W
) (
   input  logic             clk,
   input  logic             rst,
   rsa_regfile_ctrl_if.slave bus,
   input  logic             ext_start,
   output logic             core_en,
   output logic             core_rst_n,
   output logic [OP_W-1:0]  op_p,
   output logic [OP_W-1:0]  op_e,
   output logic [OP_W-1:0]  op_m,
   output logic [OP_W-1:0]  op_const,
   input  logic             core_eoc,
   input  logic [OP_W-1:0]  core_c,
   output logic             irq
);

   localparam int P_BASE = 4;
   localparam int E_BASE = P_BASE + OP_BYTES;
   localparam int M_BASE = E_BASE + OP_BYTES;
   localparam int K_BASE = M_BASE + OP_BYTES;
   localparam int C_BASE = K_BASE + OP_BYTES;

   // Counter value that, once incremented this cycle, reaches 2**TMO_W-1.
   // With the counter loaded with 0 on RUN entry this yields exactly
   // 2**TMO_W-1 RUN cycles before the timeout.
   localparam logic [TMO_W-1:0] CNT_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t            state, state_nxt;
   logic [OP_W-1:0]   p_q, e_q, m_q, k_q, c_q;
   logic [REG_W-1:0]  spare_q;
   logic [TMO_W-1:0]  cnt_q;
   logic              irq_q, done_q, tmo_q, err_q, irq_en_q;
   logic              sync1_q, sync2_q, prev_q;

   logic              ctrl_wr, clr_wr, spare_wr, op_wr;
   logic              ext_pulse, start_req, stop_req;
   logic              enter_run, capture, timeout, set_irq;
   logic [REG_W-1:0]  rdata;

   // ---------------- bus decode ----------------
   assign ctrl_wr  = bus.reg_wvld && (bus.reg_addr == ADDR_W'(1));
   assign clr_wr   = bus.reg_wvld && (bus.reg_addr == ADDR_W'(2));
   assign spare_wr = bus.reg_wvld && (bus.reg_addr == ADDR_W'(3));
   assign op_wr    = bus.reg_wvld && (int'(bus.reg_addr) >= P_BASE)
                                  && (int'(bus.reg_addr) <  C_BASE);

   // START and STOP together is a STOP only.
   assign ext_pulse = sync2_q && !prev_q;
   assign stop_req  = ctrl_wr && bus.reg_wdata[1];
   assign start_req = (ctrl_wr && bus.reg_wdata[0] && !bus.reg_wdata[1]) || ext_pulse;

   // ---------------- FSM ----------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt  = state;
      enter_run  = 1'b0;
      capture    = 1'b0;
      timeout    = 1'b0;
      core_en    = 1'b0;
      core_rst_n = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_req) begin
               state_nxt = S_RUN;
               enter_run = 1'b1;
            end
         end
         S_RUN: begin
            core_en    = 1'b1;
            core_rst_n = 1'b1;
            // eoc beats timeout, timeout beats STOP; start requests ignored.
            if (core_eoc) begin
               capture   = 1'b1;
               state_nxt = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               timeout   = 1'b1;
               state_nxt = S_IDLE;
            end else if (stop_req) begin
               state_nxt = S_IDLE;
            end
         end
         S_DONE: begin
            if (start_req) begin
               state_nxt = S_RUN;
               enter_run = 1'b1;
            end else if (stop_req) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign set_irq = (capture || timeout) && irq_en_q;

   // ---------------- registers ----------------
   // NOTE: the register bank is built from flops, not a RAM, so it is
   // cleared by reset along with everything else.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_q      <= '0;
         e_q      <= '0;
         m_q      <= '0;
         k_q      <= '0;
         c_q      <= '0;
         spare_q  <= '0;
         cnt_q    <= '0;
         irq_q    <= 1'b0;
         done_q   <= 1'b0;
         tmo_q    <= 1'b0;
         err_q    <= 1'b0;
         irq_en_q <= 1'b0;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         prev_q   <= 1'b0;
      end else begin
         sync1_q <= ext_start;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;

         if (enter_run)          cnt_q <= '0;
         else if (state == S_RUN) cnt_q <= cnt_q + 1'b1;

         // Operand writes are locked out while the core is running.
         if (op_wr && state != S_RUN) begin
            for (int k = 0; k < OP_BYTES; k++) begin
               if (bus.reg_addr == ADDR_W'(P_BASE + k)) p_q[k*REG_W +: REG_W] <= bus.reg_wdata;
               if (bus.reg_addr == ADDR_W'(E_BASE + k)) e_q[k*REG_W +: REG_W] <= bus.reg_wdata;
               if (bus.reg_addr == ADDR_W'(M_BASE + k)) m_q[k*REG_W +: REG_W] <= bus.reg_wdata;
               if (bus.reg_addr == ADDR_W'(K_BASE + k)) k_q[k*REG_W +: REG_W] <= bus.reg_wdata;
            end
         end

         if (ctrl_wr)  irq_en_q <= bus.reg_wdata[2];
         if (spare_wr) spare_q  <= bus.reg_wdata;
         if (capture)  c_q      <= core_c;

         // Sticky flags: the later assignment (set) wins over a same-cycle clear.
         if (clr_wr && bus.reg_wdata[0]) irq_q <= 1'b0;
         if (set_irq)                    irq_q <= 1'b1;

         if (enter_run || (clr_wr && bus.reg_wdata[1])) done_q <= 1'b0;
         if (capture)                                   done_q <= 1'b1;

         if (enter_run || (clr_wr && bus.reg_wdata[3])) tmo_q <= 1'b0;
         if (timeout)                                   tmo_q <= 1'b1;

         if (clr_wr && bus.reg_wdata[4]) err_q <= 1'b0;
         if (op_wr && state == S_RUN)    err_q <= 1'b1;
      end
   end

   // ---------------- read mux ----------------
   always_comb begin
      rdata = '0;
      if (bus.reg_addr == ADDR_W'(0)) begin
         rdata[4:0] = {err_q, tmo_q, (state == S_RUN), done_q, irq_q};
      end else if (bus.reg_addr == ADDR_W'(1)) begin
         rdata[2] = irq_en_q;
      end else if (bus.reg_addr == ADDR_W'(3)) begin
         rdata = spare_q;
      end
      for (int k = 0; k < OP_BYTES; k++) begin
         if (bus.reg_addr == ADDR_W'(P_BASE + k)) rdata = p_q[k*REG_W +: REG_W];
         if (bus.reg_addr == ADDR_W'(E_BASE + k)) rdata = e_q[k*REG_W +: REG_W];
         if (bus.reg_addr == ADDR_W'(M_BASE + k)) rdata = m_q[k*REG_W +: REG_W];
         if (bus.reg_addr == ADDR_W'(K_BASE + k)) rdata = k_q[k*REG_W +: REG_W];
         if (bus.reg_addr == ADDR_W'(C_BASE + k)) rdata = c_q[k*REG_W +: REG_W];
      end
   end

   assign bus.reg_rdata = rdata;

   assign op_p     = p_q;
   assign op_e     = e_q;
   assign op_m     = m_q;
   assign op_const = k_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_rsa_regfile_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rsa_regfile_ctrl
//   Directed bench for rsa_regfile_ctrl. Two instances share the register bus,
//   ext_start and core_c: dut_a (TMO_W=16) carries the main scenarios and
//   dut_t (TMO_W=4) the timeout scenario. Each has its own core_eoc.
// ---------------------------------------------------------------------------
module tb_rsa_regfile_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  addr;
   logic [7:0]  wdata;
   logic        wvld;
   logic        ext_start;
   logic        eoc_a, eoc_t;
   logic [31:0] core_c;

   logic        core_en_a, core_rst_n_a, irq_a;
   logic        core_en_t, core_rst_n_t, irq_t;
   logic [31:0] op_p_a, op_e_a, op_m_a, op_k_a;
   logic [31:0] op_p_t, op_e_t, op_m_t, op_k_t;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   rsa_regfile_ctrl_if #(.ADDR_W(5), .REG_W(8)) bus_a ();
   rsa_regfile_ctrl_if #(.ADDR_W(5), .REG_W(8)) bus_t ();

   assign bus_a.reg_addr  = addr;
   assign bus_a.reg_wdata = wdata;
   assign bus_a.reg_wvld  = wvld;
   assign bus_t.reg_addr  = addr;
   assign bus_t.reg_wdata = wdata;
   assign bus_t.reg_wvld  = wvld;

   rsa_regfile_ctrl #(.REG_W(8), .ADDR_W(5), .OP_BYTES(4), .TMO_W(16)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a.slave), .ext_start(ext_start),
      .core_en(core_en_a), .core_rst_n(core_rst_n_a),
      .op_p(op_p_a), .op_e(op_e_a), .op_m(op_m_a), .op_const(op_k_a),
      .core_eoc(eoc_a), .core_c(core_c), .irq(irq_a)
   );

   rsa_regfile_ctrl #(.REG_W(8), .ADDR_W(5), .OP_BYTES(4), .TMO_W(4)) dut_t (
      .clk(clk), .rst(rst), .bus(bus_t.slave), .ext_start(ext_start),
      .core_en(core_en_t), .core_rst_n(core_rst_n_t),
      .op_p(op_p_t), .op_e(op_e_t), .op_m(op_m_t), .op_const(op_k_t),
      .core_eoc(eoc_t), .core_c(core_c), .irq(irq_t)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      addr  = a;
      wdata = d;
      wvld  = 1'b1;
      tick();
      wvld  = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [7:0] da, output logic [7:0] dt);
      addr = a;
      #1;
      da = bus_a.reg_rdata;
      dt = bus_t.reg_rdata;
   endtask

   task automatic chk_a(input string tag, input logic [4:0] a, input logic [7:0] exp);
      logic [7:0] da, dt;
      rd(a, da, dt);
      check(tag, {24'h0, da}, {24'h0, exp});
   endtask

   task automatic chk_t(input string tag, input logic [4:0] a, input logic [7:0] exp);
      logic [7:0] da, dt;
      rd(a, da, dt);
      check(tag, {24'h0, dt}, {24'h0, exp});
   endtask

   task automatic rd32(input logic [4:0] base, output logic [31:0] wa, output logic [31:0] wt);
      logic [7:0] da, dt;
      for (int k = 0; k < 4; k++) begin
         rd(base + 5'(k), da, dt);
         wa[8*k +: 8] = da;
         wt[8*k +: 8] = dt;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] wa, wt;
      int runs;

      rst = 1'b1; addr = '0; wdata = '0; wvld = 1'b0;
      ext_start = 1'b0; eoc_a = 1'b0; eoc_t = 1'b0; core_c = '0;

      // ---- 1: reset ----
      tick();
      tick();
      rst = 1'b0;
      check("rst_irq", {31'h0, irq_a}, 32'h0);
      check("rst_core_en", {31'h0, core_en_a}, 32'h0);
      check("rst_core_rst_n", {31'h0, core_rst_n_a}, 32'h0);
      for (int a = 0; a < 24; a++) chk_a($sformatf("rst_read_%0d", a), 5'(a), 8'h00);

      // ---- 2: normal run ----
      wr(5'd4, 8'h11); wr(5'd5, 8'h00); wr(5'd6, 8'hA5); wr(5'd7, 8'hC3);
      wr(5'd8, 8'h01); wr(5'd10, 8'h01);
      chk_a("p_byte0", 5'd4, 8'h11);
      chk_a("p_byte1", 5'd5, 8'h00);
      chk_a("p_byte2", 5'd6, 8'hA5);
      chk_a("p_byte3", 5'd7, 8'hC3);
      check("op_p", op_p_a, 32'hC3A5_0011);
      check("op_e", op_e_a, 32'h0001_0001);
      wr(5'd3, 8'h5A);
      chk_a("spare", 5'd3, 8'h5A);
      wr(5'd1, 8'h04);
      chk_a("ctrl_irq_en", 5'd1, 8'h04);
      wr(5'd1, 8'h05);
      check("start_core_en", {31'h0, core_en_a}, 32'h1);
      check("start_core_rst_n", {31'h0, core_rst_n_a}, 32'h1);
      repeat (4) tick();
      core_c = 32'hCAFE_F00D; eoc_t = 1'b1;
      tick();
      eoc_t = 1'b0;
      check("t_done_core_en", {31'h0, core_en_t}, 32'h0);
      repeat (14) tick();
      chk_a("busy_status", 5'd0, 8'h04);
      core_c = 32'h1234_5678; eoc_a = 1'b1;
      tick();
      eoc_a = 1'b0;
      check("eoc_core_en", {31'h0, core_en_a}, 32'h0);
      chk_a("c_byte0", 5'd20, 8'h78);
      chk_a("c_byte1", 5'd21, 8'h56);
      chk_a("c_byte2", 5'd22, 8'h34);
      chk_a("c_byte3", 5'd23, 8'h12);
      chk_a("done_status", 5'd0, 8'h03);
      check("done_irq", {31'h0, irq_a}, 32'h1);
      chk_t("t_done_status", 5'd0, 8'h03);
      wr(5'd2, 8'h01);
      check("clr_irq", {31'h0, irq_a}, 32'h0);
      chk_a("clr_status", 5'd0, 8'h02);

      // ---- 3: timeout on the TMO_W=4 instance ----
      wr(5'd1, 8'h00);
      wr(5'd1, 8'h01);
      runs = 0;
      while (core_en_t && runs < 40) begin
         runs++;
         tick();
      end
      check("tmo_run_cycles", 32'(runs), 32'd15);
      chk_t("tmo_status", 5'd0, 8'h08);
      check("tmo_irq", {31'h0, irq_t}, 32'h0);
      rd32(5'd20, wa, wt);
      check("tmo_c_unchanged", wt, 32'hCAFE_F00D);
      chk_a("a_still_busy", 5'd0, 8'h04);

      // ---- 4: stop and lockout ----
      wr(5'd8, 8'hFF);
      check("lockout_e", op_e_a, 32'h0001_0001);
      chk_a("lockout_e_read", 5'd8, 8'h01);
      chk_a("lockout_err", 5'd0, 8'h14);
      check("idle_write_e", op_e_t, 32'h0001_00FF);
      wr(5'd1, 8'h02);
      check("stop_core_en", {31'h0, core_en_a}, 32'h0);
      chk_a("stop_status", 5'd0, 8'h10);
      wr(5'd2, 8'h10);
      chk_a("clr_err", 5'd0, 8'h00);

      // ---- 5: collisions ----
      wr(5'd1, 8'h05);
      repeat (2) tick();
      core_c = 32'hA5A5_5A5A; eoc_a = 1'b1;
      wr(5'd1, 8'h06);
      eoc_a = 1'b0;
      rd32(5'd20, wa, wt);
      check("eoc_stop_c", wa, 32'hA5A5_5A5A);
      chk_a("eoc_stop_status", 5'd0, 8'h03);
      chk_t("stop_t_status", 5'd0, 8'h00);
      wr(5'd2, 8'h01);
      chk_a("clr_irq2", 5'd0, 8'h02);
      wr(5'd1, 8'h05);
      tick();
      core_c = 32'h0BAD_BEEF; eoc_a = 1'b1;
      wr(5'd2, 8'h03);
      eoc_a = 1'b0;
      chk_a("set_beats_clr", 5'd0, 8'h03);
      check("set_beats_clr_irq", {31'h0, irq_a}, 32'h1);
      wr(5'd1, 8'h02);
      wr(5'd2, 8'h1B);
      chk_a("clr_all", 5'd0, 8'h00);
      wr(5'd1, 8'h03);
      check("start_stop_idle", {31'h0, core_en_a}, 32'h0);
      chk_a("start_stop_ctrl", 5'd1, 8'h00);
      tick();
      check("start_stop_idle2", {31'h0, core_en_a}, 32'h0);

      // ---- 6: ext_start ----
      ext_start = 1'b1;
      tick();
      tick();
      check("ext_not_yet", {31'h0, core_en_a}, 32'h0);
      tick();
      check("ext_run", {31'h0, core_en_a}, 32'h1);
      core_c = 32'h5555_AAAA; eoc_a = 1'b1;
      tick();
      eoc_a = 1'b0;
      repeat (5) tick();
      check("ext_held_one_run", {31'h0, core_en_a}, 32'h0);
      chk_a("ext_done_status", 5'd0, 8'h02);
      rd32(5'd20, wa, wt);
      check("ext_c", wa, 32'h5555_AAAA);
      ext_start = 1'b0;
      repeat (3) tick();
      ext_start = 1'b1;
      repeat (2) tick();
      check("ext2_not_yet", {31'h0, core_en_a}, 32'h0);
      tick();
      check("ext2_run", {31'h0, core_en_a}, 32'h1);
      rst = 1'b1; ext_start = 1'b0;
      tick();
      check("midrun_rst_core_en", {31'h0, core_en_a}, 32'h0);
      check("midrun_rst_core_rst_n", {31'h0, core_rst_n_a}, 32'h0);
      rst = 1'b0;
      check("midrun_rst_irq", {31'h0, irq_a}, 32'h0);
      chk_a("midrun_rst_status", 5'd0, 8'h00);
      rd32(5'd20, wa, wt);
      check("midrun_rst_c", wa, 32'h0);
      check("midrun_rst_p", op_p_a, 32'h0);
      chk_a("midrun_rst_spare", 5'd3, 8'h00);
      repeat (4) tick();
      check("post_rst_idle", {31'h0, core_en_a}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
